uart_tx_fifo: RTL and testbench

Byte buffer and transmit sequencer that sits directly upstream of the UART transmitter. Producers push bytes through a valid/ready write port. The block stores them in a synchronous FIFO and drives the transmitter's `data`/`start` inputs one byte at a time, pacing on its `busy` output. `tx_data` is held stable for the whole frame, because the transmitter samples `data[bit_index]` live while busy.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 84 ++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit-sequencer state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no bypass, so a pushed word is visible the cycle after.
module sync_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_DEPTH  = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              push_ok;
    logic              pop_ok;

    // A push is refused while full even if a pop happens on the same edge.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (count == CNT_DEPTH);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; stale words are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding the UART transmitter one frame at a time, paced on its busy flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [ADDR_W:0]        level,
    output logic                   empty,
    output logic                   full,
    output logic                   idle
);

    tx_state_e              state;
    logic                   pop;
    logic [UART_DATA_W-1:0] head_data;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (level),
        .full      (full),
        .empty     (empty)
    );

    assign wr_ready = !full;
    assign idle     = (state == IDLE) && empty;

    // Pops only when the transmitter is free, so tx_data never moves under a frame in flight.
    assign pop = !empty && ((state == IDLE) || ((state == DRAIN) && !tx_busy));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= head_data;
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        tx_data  <= head_data;
                        tx_start <= 1'b1;
                        state    <= START;
                    end else if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter that decodes tx_data live per bit.
module tb_uart_tx_fifo;

    localparam int DEPTH     = 16;
    localparam int BIT_CYC   = 4;
    localparam int FRAME_CYC = 10 * BIT_CYC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       idle;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: acts on the falling edge, so busy behaves like a register updated on the rising edge.
    int         cnt = 0;
    int         cur_bit = 0;
    int         gap = 0;
    int         gap_err = 0;
    bit         armed = 1'b0;
    bit         gap_chk = 1'b0;
    bit         prev_done = 1'b0;
    logic [7:0] shreg = 8'h00;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                tx_busy   = 1'b0;
                armed     = 1'b0;
                cnt       = 0;
                cur_bit   = 0;
                prev_done = 1'b0;
            end else if (tx_busy) begin
                cur_bit = cnt / BIT_CYC;
                if (cur_bit >= 1 && cur_bit <= 8 && (cnt % BIT_CYC) == BIT_CYC / 2)
                    shreg[cur_bit-1] = tx_data[cur_bit-1];
                cnt++;
                if (cnt == FRAME_CYC) begin
                    tx_busy   = 1'b0;
                    rx_q.push_back(shreg);
                    gap       = 0;
                    prev_done = 1'b1;
                end
            end else begin
                gap++;
                if (armed) begin
                    tx_busy = 1'b1;
                    cnt     = 0;
                    armed   = 1'b0;
                    if (gap_chk && prev_done && gap != 2) gap_err++;
                end else if (tx_start) begin
                    armed = 1'b1;
                end
            end
        end
    end

    // tx_data may only change on the cycle tx_start rises (a pop).
    logic [7:0] prev_data;
    logic       prev_start = 1'b0;
    logic       prev_reset = 1'b1;
    int         stab_err = 0;
    int         max_level = 0;

    always @(negedge clk) begin
        if (!reset && !prev_reset && tx_data !== prev_data && !(tx_start && !prev_start))
            stab_err++;
        prev_data  = tx_data;
        prev_start = tx_start;
        prev_reset = reset;
        if (int'(level) > max_level) max_level = int'(level);
    end

    task automatic push(input logic [7:0] b);
        logic rdy;
        int   budget;
        wr_valid = 1'b1;
        wr_data  = b;
        budget   = 0;
        do begin
            rdy = wr_ready;
            tick();
            budget++;
        end while (!rdy && budget < 2000);
        check("push_accept", rdy, 1);
        exp_q.push_back(b);
        wr_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int budget = 0;
        while (rx_q.size() < n && budget < 5000) begin
            tick();
            budget++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    task automatic compare_q(input string tag);
        int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            check(tag, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        int starts;

        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst_wr_ready", wr_ready, 1);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_start", tx_start, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_idle", idle, 1);
        reset = 1'b0;
        tick();

        // Single byte: accept at E0, start high after E1 and E2, low after E3
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_valid = 1'b0;
        check("e0_level", level, 1);
        check("e0_start", tx_start, 0);
        tick();
        check("e1_start", tx_start, 1);
        check("e1_data", tx_data, 8'hA5);
        check("e1_level", level, 0);
        check("e1_idle", idle, 0);
        tick();
        check("e2_start", tx_start, 1);
        tick();
        check("e3_start", tx_start, 0);
        check("e3_busy", tx_busy, 1);
        wait_rx(1);
        check("single_rx", rx_q[0], 8'hA5);
        check("single_data_hold", tx_data, 8'hA5);
        tick();
        check("single_idle", idle, 1);
        rx_q.delete();

        // Burst 0x01..0x10, then keep writing into a full FIFO
        gap_chk   = 1'b1;
        prev_done = 1'b0;
        for (int i = 1; i <= 16; i++) push(8'(i));
        check("burst_level", level, 15);
        check("burst_not_full", full, 0);
        push(8'h11);
        check("full_flag", full, 1);
        check("full_wr_ready", wr_ready, 0);
        check("full_level", level, 16);
        wr_valid = 1'b1;
        wr_data  = 8'h12;
        stall    = 0;
        while (!wr_ready && stall < 2000) begin
            tick();
            stall++;
        end
        check("full_stalled", stall > 10, 1);
        check("pop_frees_slot", level, 15);
        push(8'h12);
        check("retry_level", level, 16);
        push(8'h13);
        push(8'h14);
        wait_rx(20);
        compare_q("burst_rx");
        gap_chk = 1'b0;
        check("gap_2cyc_err", gap_err, 0);
        check("stability_err", stab_err, 0);
        tick();
        check("burst_idle", idle, 1);

        // Reset during bit 4 with 5 bytes queued
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        stall = 0;
        while (!(tx_busy && cur_bit == 4) && stall < 2000) begin
            tick();
            stall++;
        end
        check("mid_frame_reached", tx_busy && cur_bit == 4, 1);
        check("mid_level", level, 5);
        reset = 1'b1;
        tick();
        check("mrst_level", level, 0);
        check("mrst_start", tx_start, 0);
        check("mrst_data", tx_data, 8'h00);
        check("mrst_idle", idle, 1);
        reset = 1'b0;
        starts = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tx_start) starts++;
        end
        check("mrst_no_start", starts, 0);
        check("mrst_no_frames", rx_q.size(), 0);
        rx_q.delete();
        exp_q.delete();

        // Pointer wrap: 40 bytes with random gaps
        for (int i = 0; i < 40; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_rx(40);
        compare_q("wrap_rx");
        check("max_level", max_level <= DEPTH, 1);
        check("stability_err_end", stab_err, 0);
        tick();
        check("final_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
